// File: rtl/dsp_add3_arbiter_if.sv
// ----------------------------------------------------------------------------
// dsp_add3_arbiter_if
// Bundles the requester handshakes, the DSP operand/result path and the
// response/status signals of the shared DSP adder arbiter.
//
// Signal summary:
//   hold         1 = suppress new grants (in-flight operations still drain)
//   req_valid    per-requester operand set valid
//   req_ready    per-requester accept, one-hot or zero
//   req_op0/1/2  per-requester signed 18-bit operands, requester i at [18i+17:18i]
//   req_cin      per-requester carry-in
//   dsp_op0/1/2  registered operands towards the DSP
//   dsp_cin      registered carry-in towards the DSP
//   dsp_result   48-bit DSP sum returning from the DSP
//   rsp_valid    one-hot result strobe to the owning requester
//   rsp_id       ID of the requester owning rsp_result
//   rsp_result   result forwarded from dsp_result
//   busy         1 while any operation is in flight
//   issue_count  total accepted operations, wraps at 2^32
//
// Modports: slave = arbiter side, master = requesters plus DSP side.
// ----------------------------------------------------------------------------
interface dsp_add3_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic                  hold;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*18-1:0] req_op0;
  logic [NUM_REQ*18-1:0] req_op1;
  logic [NUM_REQ*18-1:0] req_op2;
  logic [NUM_REQ-1:0]    req_cin;
  logic [17:0]           dsp_op0;
  logic [17:0]           dsp_op1;
  logic [17:0]           dsp_op2;
  logic                  dsp_cin;
  logic [47:0]           dsp_result;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [47:0]           rsp_result;
  logic                  busy;
  logic [31:0]           issue_count;

  modport slave (
    input  hold, req_valid, req_op0, req_op1, req_op2, req_cin, dsp_result,
    output req_ready, dsp_op0, dsp_op1, dsp_op2, dsp_cin,
    output rsp_valid, rsp_id, rsp_result, busy, issue_count
  );

  modport master (
    output hold, req_valid, req_op0, req_op1, req_op2, req_cin, dsp_result,
    input  req_ready, dsp_op0, dsp_op1, dsp_op2, dsp_cin,
    input  rsp_valid, rsp_id, rsp_result, busy, issue_count
  );
endinterface

// File: rtl/dsp_add3_arbiter.sv
// ----------------------------------------------------------------------------
// dsp_add3_arbiter
// Round-robin arbiter/sequencer sharing one pipelined A+B+C+CIN DSP adder
// among NUM_REQ requesters. Accepted operand sets are registered onto the DSP
// inputs; a requester-ID tag pipeline of DSP_LAT+1 stages tracks each
// operation and routes the returning sum to its owner.
//
// Ports:
//   clk     system clock
//   areset  asynchronous reset, active-high
//   bus     dsp_add3_arbiter_if.slave (handshakes, DSP path, responses,
//           hold, busy, issue_count)
// ----------------------------------------------------------------------------
module dsp_add3_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DSP_LAT = 3
) (
  input  logic               clk,
  input  logic               areset,
  dsp_add3_arbiter_if.slave  bus
);

  localparam int OPW  = 18;
  localparam int NSTG = DSP_LAT + 1;

  // (base + off) mod NUM_REQ; base and off are both below NUM_REQ, so one
  // conditional subtraction is enough and non-power-of-two counts work.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_REQ)) begin
      sum = sum - 32'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               found_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               hs_s;
  logic [31:0]        sel_lsb_s;
  logic [NUM_REQ-1:0] ready_s;

  logic [OPW-1:0]     op0_q, op0_d;
  logic [OPW-1:0]     op1_q, op1_d;
  logic [OPW-1:0]     op2_q, op2_d;
  logic               cin_q, cin_d;

  logic [NSTG-1:0]    tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]    tag_id_q [NSTG];
  logic [ID_W-1:0]    tag_id_d [NSTG];

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               busy_q, busy_d;
  logic [31:0]        cnt_q, cnt_d;

  // Round-robin search: first valid requester at or above the pointer.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    for (int unsigned off = 32'd0; off < 32'(NUM_REQ); off++) begin
      if (!found_s && bus.req_valid[wrap_add(ptr_q, off)]) begin
        found_s   = 1'b1;
        gnt_idx_s = wrap_add(ptr_q, off);
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Grant qualification by hold and one-hot ready generation.
  always_comb begin
    hs_s      = found_s & ~bus.hold;
    sel_lsb_s = OPW * 32'(gnt_idx_s);
    if (hs_s) begin
      ready_s = NUM_REQ'(1'b1) << gnt_idx_s;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state: operand register, tag shift, response decode, counters.
  always_comb begin
    op0_d    = '0;
    op1_d    = '0;
    op2_d    = '0;
    cin_d    = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    if (hs_s) begin
      op0_d = bus.req_op0[sel_lsb_s +: OPW];
      op1_d = bus.req_op1[sel_lsb_s +: OPW];
      op2_d = bus.req_op2[sel_lsb_s +: OPW];
      cin_d = bus.req_cin[gnt_idx_s];
      ptr_d = wrap_add(gnt_idx_s, 32'd1);
      cnt_d = cnt_q + 32'd1;
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end

    // Tag pipeline never stalls; stage 0 is the newly issued operation.
    tag_vld_d   = {tag_vld_q[NSTG-2:0], hs_s};
    tag_id_d[0] = gnt_idx_s;
    for (int k = 1; k < NSTG; k++) begin
      tag_id_d[k] = tag_id_q[k-1];
    end

    // Last tag stage lines up with dsp_result one cycle later; rsp_id holds
    // its previous owner while idle.
    if (tag_vld_q[NSTG-1]) begin
      rsp_valid_d = NUM_REQ'(1'b1) << tag_id_q[NSTG-1];
      rsp_id_d    = tag_id_q[NSTG-1];
    end else begin
      rsp_valid_d = '0;
      rsp_id_d    = rsp_id_q;
    end

    busy_d = |tag_vld_d;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ptr_q       <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      cin_q       <= 1'b0;
      tag_vld_q   <= '0;
      for (int k = 0; k < NSTG; k++) begin
        tag_id_q[k] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      ptr_q       <= ptr_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      cin_q       <= cin_d;
      tag_vld_q   <= tag_vld_d;
      for (int k = 0; k < NSTG; k++) begin
        tag_id_q[k] <= tag_id_d[k];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.dsp_op0     = op0_q;
  assign bus.dsp_op1     = op1_q;
  assign bus.dsp_op2     = op2_q;
  assign bus.dsp_cin     = cin_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  // The result is passed straight through; its timing matches rsp_valid_q.
  assign bus.rsp_result  = bus.dsp_result;
  assign bus.busy        = busy_q;
  assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_dsp_add3_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dsp_add3_arbiter
// Directed testbench for dsp_add3_arbiter with a behavioural DSP adder model
// (one input register plus DSP_LAT pipeline stages).
// ----------------------------------------------------------------------------
module tb_dsp_add3_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DSP_LAT = 3;

  logic clk = 1'b0;
  logic areset;
  int   checks = 0;
  int   passes = 0;

  dsp_add3_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  dsp_add3_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DSP_LAT(DSP_LAT)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // DSP model: sum registered on the edge after the operands appear, then
  // DSP_LAT more stages.
  logic [47:0] dsp_pipe [DSP_LAT+1];
  always @(posedge clk) begin
    dsp_pipe[0] <= 48'($signed(bus.dsp_op0)) + 48'($signed(bus.dsp_op1))
                 + 48'($signed(bus.dsp_op2)) + {47'd0, bus.dsp_cin};
    for (int k = 1; k <= DSP_LAT; k++) dsp_pipe[k] <= dsp_pipe[k-1];
  end
  assign bus.dsp_result = dsp_pipe[DSP_LAT];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] c, input logic ci);
    bus.req_op0[idx*18 +: 18] = a;
    bus.req_op1[idx*18 +: 18] = b;
    bus.req_op2[idx*18 +: 18] = c;
    bus.req_cin[idx] = ci;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    #3;
    checks++;
    if ({bus.dsp_op0, bus.dsp_op1, bus.dsp_op2, bus.dsp_cin} !== 55'd0)
      $display("FAIL reset_dsp_ops: got %h want 0", {bus.dsp_op0, bus.dsp_op1, bus.dsp_op2, bus.dsp_cin});
    else passes++;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.busy} !== 7'd0)
      $display("FAIL reset_rsp_busy: got %b want 0", {bus.rsp_valid, bus.rsp_id, bus.busy});
    else passes++;
    checks++;
    if (bus.issue_count !== 32'd0)
      $display("FAIL reset_issue_count: got %0d want 0", bus.issue_count);
    else passes++;
    tick();
    areset = 1'b0;
    tick();
    checks++;
    if (bus.req_ready !== 4'b0000)
      $display("FAIL reset_ready_idle: got %b want 0000", bus.req_ready);
    else passes++;
  endtask

  task automatic test_single();
    set_ops(1, 18'd100, -18'sd50, 18'd7, 1'b1);
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010)
      $display("FAIL single_ready: got %b want 0010", bus.req_ready);
    else passes++;
    tick();
    bus.req_valid = 4'b0000;
    checks++;
    if ({bus.dsp_op0, bus.dsp_op1, bus.dsp_op2, bus.dsp_cin} !== {18'd100, 18'h3FFCE, 18'd7, 1'b1})
      $display("FAIL single_dsp_ops: got %h %h %h %b want 00064 3ffce 00007 1",
               bus.dsp_op0, bus.dsp_op1, bus.dsp_op2, bus.dsp_cin);
    else passes++;
    checks++;
    if (bus.issue_count !== 32'd1 || bus.busy !== 1'b1)
      $display("FAIL single_count_busy: got %0d/%b want 1/1", bus.issue_count, bus.busy);
    else passes++;
    tick();
    checks++;
    if (bus.dsp_op0 !== 18'd0 || bus.rsp_valid !== 4'b0000)
      $display("FAIL single_idle_ops: got op0=%h rsp=%b want 0/0000", bus.dsp_op0, bus.rsp_valid);
    else passes++;
    tick();
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0000)
      $display("FAIL single_early_rsp: got %b want 0000", bus.rsp_valid);
    else passes++;
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 48'd58)
      $display("FAIL single_rsp: got %b id=%0d res=%0d want 0010 id=1 res=58",
               bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    else passes++;
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_id !== 2'd1 || bus.busy !== 1'b0)
      $display("FAIL single_after: got %b id=%0d busy=%b want 0000 id=1 busy=0",
               bus.rsp_valid, bus.rsp_id, bus.busy);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [47:0] exp_res [4];
    logic        exp_busy;
    int          k;
    exp_res[0] = 48'd1003;
    exp_res[1] = 48'd2003;
    exp_res[2] = 48'd3001;
    exp_res[3] = 48'd4001;
    do_reset();
    set_ops(0, 18'd1000, 18'd0,    18'd3, 1'b0);
    set_ops(1, 18'd2000, -18'sd1,  18'd3, 1'b1);
    set_ops(2, 18'd3000, -18'sd2,  18'd3, 1'b0);
    set_ops(3, 18'd4000, -18'sd3,  18'd3, 1'b1);
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 13; j++) begin
      if (j == 8) bus.req_valid = 4'b0000;
      #1;
      if (j < 8) begin
        checks++;
        if (bus.req_ready !== (4'b0001 << (j % 4)))
          $display("FAIL rr_grant_%0d: got %b want %b", j, bus.req_ready, 4'b0001 << (j % 4));
        else passes++;
      end
      tick();
      if (j >= 4 && j <= 11) begin
        k = (j - 4) % 4;
        checks++;
        if (bus.rsp_valid !== (4'b0001 << k) || bus.rsp_id !== 2'(k) || bus.rsp_result !== exp_res[k])
          $display("FAIL rr_rsp_%0d: got %b id=%0d res=%0d want %b id=%0d res=%0d", j,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_result, 4'b0001 << k, k, exp_res[k]);
        else passes++;
      end
      if (j == 12) begin
        checks++;
        if (bus.rsp_valid !== 4'b0000)
          $display("FAIL rr_drained: got %b want 0000", bus.rsp_valid);
        else passes++;
      end
      exp_busy = (j <= 10);
      checks++;
      if (bus.busy !== exp_busy)
        $display("FAIL rr_busy_%0d: got %b want %b", j, bus.busy, exp_busy);
      else passes++;
    end
    checks++;
    if (bus.issue_count !== 32'd8)
      $display("FAIL rr_issue_count: got %0d want 8", bus.issue_count);
    else passes++;
  endtask

  task automatic test_pointer_skip();
    bus.req_valid = 4'b0010;
    #1;
    tick();
    bus.req_valid = 4'b1001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000)
      $display("FAIL skip_first: got %b want 1000", bus.req_ready);
    else passes++;
    tick();
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001)
      $display("FAIL skip_second: got %b want 0001", bus.req_ready);
    else passes++;
    tick();
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010)
      $display("FAIL skip_ptr_end: got %b want 0010", bus.req_ready);
    else passes++;
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_hold();
    bus.req_valid = 4'b0011;
    #1;
    tick();
    tick();
    bus.hold      = 1'b1;
    bus.req_valid = 4'b0100;
    for (int t = 1; t <= 5; t++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000)
        $display("FAIL hold_ready_%0d: got %b want 0000", t, bus.req_ready);
      else passes++;
      tick();
      if (t == 3) begin
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 48'd2003)
          $display("FAIL hold_rsp_a: got %b id=%0d res=%0d want 0010 id=1 res=2003",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        else passes++;
      end
      if (t == 4) begin
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 48'd1003)
          $display("FAIL hold_rsp_b: got %b id=%0d res=%0d want 0001 id=0 res=1003",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        else passes++;
      end
    end
    checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL hold_busy_fall: got %b want 0", bus.busy);
    else passes++;
    bus.hold = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100)
      $display("FAIL hold_release_grant: got %b want 0100", bus.req_ready);
    else passes++;
    tick();
    bus.req_valid = 4'b0000;
    checks++;
    if (bus.issue_count !== 32'd14)
      $display("FAIL hold_issue_count: got %0d want 14", bus.issue_count);
    else passes++;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_midflight();
    logic any_rsp;
    bus.req_valid = 4'b1111;
    #1;
    tick();
    tick();
    tick();
    bus.req_valid = 4'b0000;
    #4;
    areset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.issue_count !== 32'd0)
      $display("FAIL midrst_immediate: got busy=%b cnt=%0d want 0/0", bus.busy, bus.issue_count);
    else passes++;
    checks++;
    if (bus.dsp_op0 !== 18'd0 || bus.dsp_cin !== 1'b0 || bus.rsp_id !== 2'd0)
      $display("FAIL midrst_dsp: got op0=%h cin=%b id=%0d want 0/0/0", bus.dsp_op0, bus.dsp_cin, bus.rsp_id);
    else passes++;
    tick();
    tick();
    areset = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001)
      $display("FAIL midrst_ptr: got %b want 0001", bus.req_ready);
    else passes++;
    bus.req_valid = 4'b0000;
    any_rsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_rsp = any_rsp | (|bus.rsp_valid);
    end
    checks++;
    if (any_rsp !== 1'b0 || bus.issue_count !== 32'd0)
      $display("FAIL midrst_no_rsp: got rsp_seen=%b cnt=%0d want 0/0", any_rsp, bus.issue_count);
    else passes++;
  endtask

  task automatic test_back_to_back_extreme();
    set_ops(2, 18'h20000, 18'h20000, 18'h20000, 1'b1);
    set_ops(3, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 1'b1);
    bus.req_valid = 4'b1100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100)
      $display("FAIL ext_first_grant: got %b want 0100", bus.req_ready);
    else passes++;
    tick();
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000 || bus.dsp_op0 !== 18'h20000 || bus.dsp_op2 !== 18'h20000)
      $display("FAIL ext_second_grant: got %b op0=%h op2=%h want 1000 20000 20000",
               bus.req_ready, bus.dsp_op0, bus.dsp_op2);
    else passes++;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_id !== 2'd2 || bus.rsp_result !== 48'hFFFF_FFFA_0001)
      $display("FAIL ext_min_sum: got %b id=%0d res=%h want 0100 id=2 res=fffffffa0001",
               bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    else passes++;
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b1000 || bus.rsp_id !== 2'd3 || bus.rsp_result !== 48'h0000_0005_FFFE)
      $display("FAIL ext_max_sum: got %b id=%0d res=%h want 1000 id=3 res=00000005fffe",
               bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    else passes++;
    tick();
  endtask

  initial begin
    areset        = 1'b1;
    bus.hold      = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_op0   = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_cin   = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_hold();
    test_reset_midflight();
    test_back_to_back_extreme();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
